// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit nibble adder
// over WIDTH/4 cycles (LSB nibble first). The result is delivered through a
// valid/ready handshake.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N    = WIDTH / 4;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry_q;
  logic [IDXW-1:0]   idx;

  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [4:0]        nib_sum;

  // Shared nibble adder: picks the current nibble pair and adds the carry.
  assign a_nib   = a_q[{idx, 2'b00} +: 4];
  assign b_nib   = b_q[{idx, 2'b00} +: 4];
  assign nib_sum = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};

  // Sequencer: accepts a request, steps through the nibbles, holds the result.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so it lives inside the clocked block and
    // every state register, including the operand latches, is cleared here.
    if (rst) begin
      state   <= IDLE;
      ready   <= 1'b1;
      valid   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments: every read below sees the value from
      // before this edge, so nib_sum and idx stay consistent within a cycle.
      unique case (state)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
            ready   <= 1'b0;
            state   <= RUN;
          end
        end

        RUN: begin
          sum[{idx, 2'b00} +: 4] <= nib_sum[3:0];
          carry_q                <= nib_sum[4];
          if (idx == IDX_LAST) begin
            cout  <= nib_sum[4];
            // Overflow: operands share a sign and the new MSB differs from it.
            ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (nib_sum[3] != a_q[WIDTH-1]);
            valid <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        DONE: begin
          if (out_ready) begin
            valid <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          ready <= 1'b1;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
